// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues word reads on the instruction bus and buffers tagged responses for Decode.
// Optional build macro FETCH_MISALIGN_CHECK_EN reports misaligned redirect targets instead of silently aligning them.
module fetch_unit #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        ibus_rd_en,
    output logic [31:0] ibus_addr,
    input  logic [31:0] ibus_rd_data,
    input  logic        ibus_inst_access_fault,
    input  logic        redirect,
    input  logic [31:0] redirect_addr,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_fault,
    output logic        inst_misaligned
);

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        fault;
        logic        mis;
    } entry_t;

    logic [31:0] r_pc;
    logic [31:0] r_reqPc;
    logic        r_reqFault;
    logic        r_inflight;
    logic        r_halted;
    logic [1:0]  r_count;
    entry_t      r_entry0;
    entry_t      r_entry1;

    logic        w_pop;
    logic        w_issue;
    logic        w_push;
    logic [2:0]  w_occupancy;
    logic [1:0]  w_writeIdx;
    logic [31:0] w_redirectPc;
    entry_t      w_pushEntry;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic        r_misPending;
    logic        w_misaligned;
`endif

    // Occupancy counts the word still on the bus so a new request can never overflow the buffer.
    always_comb begin
        w_pop       = (r_count != 2'd0) && inst_ready;
        w_occupancy = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
        w_issue     = !rst && !redirect && !r_halted && (w_occupancy < 3'(FIFO_DEPTH));
        w_writeIdx  = r_count - {1'b0, w_pop};
        w_pushEntry.inst  = r_reqFault ? 32'h0 : ibus_rd_data;
        w_pushEntry.pc    = r_reqPc;
        w_pushEntry.fault = r_reqFault;
        w_pushEntry.mis   = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
        w_misaligned = (redirect_addr[1:0] != 2'b00);
        w_redirectPc = redirect_addr;
        w_push       = r_inflight || r_misPending;
        if (r_misPending) begin
            w_pushEntry.inst  = 32'h0;
            w_pushEntry.pc    = r_pc;
            w_pushEntry.fault = 1'b0;
            w_pushEntry.mis   = 1'b1;
        end
`else
        w_redirectPc = redirect_addr & 32'hFFFF_FFFC;
        w_push       = r_inflight;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= RESET_ADDR;
            r_reqPc    <= 32'h0;
            r_reqFault <= 1'b0;
            r_inflight <= 1'b0;
            r_halted   <= 1'b0;
            r_count    <= 2'd0;
            r_entry0   <= '0;
            r_entry1   <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
            r_misPending <= 1'b0;
`endif
        end else if (redirect) begin
            // The response for last cycle's request, if any, is dropped by clearing inflight.
            r_count    <= 2'd0;
            r_inflight <= 1'b0;
            r_pc       <= w_redirectPc;
`ifdef FETCH_MISALIGN_CHECK_EN
            r_halted     <= w_misaligned;
            r_misPending <= w_misaligned;
`else
            r_halted   <= 1'b0;
`endif
        end else begin
            if (w_pop) begin
                r_entry0 <= r_entry1;
            end
            if (w_push) begin
                if (w_writeIdx == 2'd0) begin
                    r_entry0 <= w_pushEntry;
                end else begin
                    r_entry1 <= w_pushEntry;
                end
            end
            r_count    <= w_writeIdx + {1'b0, w_push};
            r_inflight <= w_issue;
`ifdef FETCH_MISALIGN_CHECK_EN
            r_misPending <= 1'b0;
`endif
            if (w_issue) begin
                r_pc       <= r_pc + 32'd4;
                r_reqPc    <= r_pc;
                r_reqFault <= ibus_inst_access_fault;
                if (ibus_inst_access_fault) begin
                    r_halted <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        ibus_rd_en      = w_issue;
`ifdef FETCH_MISALIGN_CHECK_EN
        ibus_addr       = {r_pc[31:2], 2'b00};
`else
        ibus_addr       = r_pc;
`endif
        inst_valid      = (r_count != 2'd0);
        inst            = inst_valid ? r_entry0.inst : 32'h0;
        inst_pc         = inst_valid ? r_entry0.pc : 32'h0;
        inst_fault      = inst_valid && r_entry0.fault;
        inst_misaligned = inst_valid && r_entry0.mis;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: queue-based reference model compared every cycle,
// plus directed sequences with hand-computed expectations and a randomized phase.
module tb_fetch_unit;

    localparam logic [31:0] RESET_ADDR = 32'h0000_0000;
    localparam logic [31:0] ROM_KEY    = 32'hA5A5_0000;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        fault;
        logic        mis;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        ibus_rd_en;
    logic [31:0] ibus_addr;
    logic [31:0] romData;
    logic        ibus_inst_access_fault;
    logic        redirect;
    logic [31:0] redirect_addr;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_fault;
    logic        inst_misaligned;

    logic        faultEn;
    logic [31:0] faultAddr;
    logic        checkEn;
    int          nChecks = 0;
    int          nFails  = 0;

    // Reference model state: next fetch address, outstanding request, buffered entries.
    logic [31:0] mPc;
    logic [31:0] mReqPc;
    logic        mReqFault;
    logic        mInflight;
    logic        mHalted;
    logic        mMisPend;
    entry_t      mQ[$];

    fetch_unit #(.RESET_ADDR(RESET_ADDR), .FIFO_DEPTH(2)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .ibus_rd_en             (ibus_rd_en),
        .ibus_addr              (ibus_addr),
        .ibus_rd_data           (romData),
        .ibus_inst_access_fault (ibus_inst_access_fault),
        .redirect               (redirect),
        .redirect_addr          (redirect_addr),
        .inst_valid             (inst_valid),
        .inst_ready             (inst_ready),
        .inst                   (inst),
        .inst_pc                (inst_pc),
        .inst_fault             (inst_fault),
        .inst_misaligned        (inst_misaligned)
    );

    always #5 clk = ~clk;

    // ROM returns addr ^ key one cycle after a request, garbage otherwise.
    always @(posedge clk) begin
        romData <= ibus_rd_en ? (ibus_addr ^ ROM_KEY) : 32'hDEAD_BEEF;
    end

    assign ibus_inst_access_fault = faultEn && (ibus_addr == faultAddr);

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic rdy, input logic rd, input logic [31:0] ra);
        @(posedge clk);
        #1;
        rst           = r;
        inst_ready    = rdy;
        redirect      = rd;
        redirect_addr = ra;
    endtask

    // Compare DUT against the model, then advance the model to the next edge.
    always @(negedge clk) begin : compareProc
        entry_t head;
        entry_t e;
        logic   popNow;
        logic   expRdEn;
        int     occ;
        popNow  = (mQ.size() > 0) && inst_ready;
        occ     = mQ.size() + int'(mInflight) - int'(popNow);
        expRdEn = !rst && !redirect && !mHalted && (occ < 2);
        head    = (mQ.size() > 0) ? mQ[0] : '0;
        if (checkEn) begin
            checkOutput("rdEn", {31'b0, ibus_rd_en}, {31'b0, expRdEn});
            if (expRdEn) checkOutput("addr", ibus_addr, mPc);
            checkOutput("valid", {31'b0, inst_valid}, {31'b0, mQ.size() > 0});
            checkOutput("inst", inst, head.inst);
            checkOutput("instPc", inst_pc, head.pc);
            checkOutput("instFault", {31'b0, inst_fault}, {31'b0, head.fault});
            checkOutput("instMis", {31'b0, inst_misaligned}, {31'b0, head.mis});
        end
        if (rst) begin
            mPc = RESET_ADDR; mInflight = 0; mHalted = 0; mMisPend = 0; mReqFault = 0; mReqPc = 0;
            mQ.delete();
        end else if (redirect) begin
            mQ.delete();
            mInflight = 0;
            mHalted   = 0;
            mMisPend  = 0;
`ifdef FETCH_MISALIGN_CHECK_EN
            mPc = redirect_addr;
            if (redirect_addr[1:0] != 2'b00) begin
                mHalted  = 1;
                mMisPend = 1;
            end
`else
            mPc = {redirect_addr[31:2], 2'b00};
`endif
        end else begin
            if (popNow) void'(mQ.pop_front());
            if (mInflight) begin
                e.inst  = mReqFault ? 32'h0 : (mReqPc ^ ROM_KEY);
                e.pc    = mReqPc;
                e.fault = mReqFault;
                e.mis   = 1'b0;
                mQ.push_back(e);
            end
            if (mMisPend) begin
                e.inst = 32'h0; e.pc = mPc; e.fault = 1'b0; e.mis = 1'b1;
                mQ.push_back(e);
                mMisPend = 0;
            end
            if (expRdEn) begin
                mReqPc    = mPc;
                mReqFault = faultEn && (mPc == faultAddr);
                if (mReqFault) mHalted = 1;
                mPc       = mPc + 32'd4;
                mInflight = 1;
            end else begin
                mInflight = 0;
            end
        end
    end

    initial begin : stimulusProc
        int          r;
        int          k;
        int          rdCount;
        logic        found;
        logic        rdy;
        logic [31:0] a;
        rst = 1; inst_ready = 1; redirect = 0; redirect_addr = 0;
        faultEn = 0; faultAddr = 0; checkEn = 0;
        mQ.delete(); mPc = 0; mReqPc = 0; mReqFault = 0; mInflight = 0; mHalted = 0; mMisPend = 0;
        repeat (2) @(posedge clk);
        checkEn = 1;
        @(negedge clk);
        checkOutput("rstValid", {31'b0, inst_valid}, 32'd0);
        checkOutput("rstRdEn", {31'b0, ibus_rd_en}, 32'd0);
        checkOutput("rstInst", inst, 32'h0);

        $display("[TB] startup stream from RESET_ADDR");
        applyStimulus(0, 1, 0, 0);
        @(negedge clk);
        checkOutput("firstRdEn", {31'b0, ibus_rd_en}, 32'd1);
        checkOutput("firstAddr", ibus_addr, 32'h0);
        @(negedge clk);
        checkOutput("secondAddr", ibus_addr, 32'h4);
        checkOutput("validCyc1", {31'b0, inst_valid}, 32'd0);
        @(negedge clk);
        checkOutput("validCyc2", {31'b0, inst_valid}, 32'd1);
        checkOutput("pcCyc2", inst_pc, 32'h0);
        checkOutput("instCyc2", inst, 32'hA5A5_0000);
        @(negedge clk);
        checkOutput("pcCyc3", inst_pc, 32'h4);
        checkOutput("instCyc3", inst, 32'hA5A5_0004);

        $display("[TB] decode stall");
        repeat (5) applyStimulus(0, 1, 0, 0);
        repeat (5) applyStimulus(0, 0, 0, 0);
        @(negedge clk);
        checkOutput("stallRdEn", {31'b0, ibus_rd_en}, 32'd0);
        checkOutput("stallValid", {31'b0, inst_valid}, 32'd1);
        repeat (8) applyStimulus(0, 1, 0, 0);

        $display("[TB] redirect to 0x100");
        applyStimulus(0, 1, 1, 32'h0000_0100);
        applyStimulus(0, 1, 0, 0);
        @(negedge clk);
        checkOutput("redirRdEn", {31'b0, ibus_rd_en}, 32'd1);
        checkOutput("redirAddr", ibus_addr, 32'h100);
        applyStimulus(0, 1, 0, 0);
        @(negedge clk);
        checkOutput("redirGap", {31'b0, inst_valid}, 32'd0);
        applyStimulus(0, 1, 0, 0);
        @(negedge clk);
        checkOutput("redirValid", {31'b0, inst_valid}, 32'd1);
        checkOutput("redirPc", inst_pc, 32'h100);
        checkOutput("redirInst", inst, 32'hA5A5_0100);

        $display("[TB] access fault at 0x1000");
        faultAddr = 32'h0000_1000;
        faultEn   = 1;
        applyStimulus(0, 1, 1, 32'h0000_0FF8);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            applyStimulus(0, 1, 0, 0);
            @(negedge clk);
            if (inst_valid && inst_pc == 32'h1000) found = 1;
        end
        checkOutput("faultSeen", {31'b0, found}, 32'd1);
        if (found) begin
            checkOutput("faultFlag", {31'b0, inst_fault}, 32'd1);
            checkOutput("faultInst", inst, 32'h0);
        end
        rdCount = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 1, 0, 0);
            @(negedge clk);
            if (ibus_rd_en) rdCount++;
        end
        checkOutput("haltNoReq", rdCount, 32'd0);
        checkOutput("haltEmpty", {31'b0, inst_valid}, 32'd0);
        faultEn = 0;

        $display("[TB] misaligned redirect to 0x102");
        applyStimulus(0, 1, 1, 32'h0000_0102);
        applyStimulus(0, 1, 0, 0);
        @(negedge clk);
`ifdef FETCH_MISALIGN_CHECK_EN
        checkOutput("misNoReq", {31'b0, ibus_rd_en}, 32'd0);
        applyStimulus(0, 1, 0, 0);
        @(negedge clk);
        checkOutput("misValid", {31'b0, inst_valid}, 32'd1);
        checkOutput("misFlag", {31'b0, inst_misaligned}, 32'd1);
        checkOutput("misPc", inst_pc, 32'h102);
        checkOutput("misInst", inst, 32'h0);
        applyStimulus(0, 1, 0, 0);
        @(negedge clk);
        checkOutput("misHalt", {31'b0, ibus_rd_en}, 32'd0);
`else
        checkOutput("alignRdEn", {31'b0, ibus_rd_en}, 32'd1);
        checkOutput("alignAddr", ibus_addr, 32'h100);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 1, 0, 0);
        @(negedge clk);
        checkOutput("alignPc", inst_pc, 32'h100);
        checkOutput("alignMis", {31'b0, inst_misaligned}, 32'd0);
`endif
        applyStimulus(0, 1, 1, 32'h0000_0200);
        repeat (6) applyStimulus(0, 1, 0, 0);

        $display("[TB] reset mid-stream");
        applyStimulus(1, 1, 0, 0);
        @(negedge clk);
        checkOutput("midRstRdEn", {31'b0, ibus_rd_en}, 32'd0);
        checkOutput("midRstBuffered", {31'b0, inst_valid}, 32'd1);
        applyStimulus(0, 1, 0, 0);
        @(negedge clk);
        checkOutput("postRstValid", {31'b0, inst_valid}, 32'd0);
        checkOutput("postRstRdEn", {31'b0, ibus_rd_en}, 32'd1);
        checkOutput("postRstAddr", ibus_addr, RESET_ADDR);

        $display("[TB] randomized phase");
        for (int cyc = 0; cyc < 2500; cyc++) begin
            r   = $urandom_range(0, 99);
            rdy = ($urandom_range(0, 3) != 0);
            if (r == 99) begin
                applyStimulus(1, rdy, 0, 0);
            end else if (r < 4) begin
                k = $urandom_range(0, 3);
                case (k)
                    0:       a = $urandom & 32'hFFFF_FFFC;
                    1:       a = $urandom;
                    2:       a = 32'hFFFF_FFF0;
                    default: a = 32'h0000_1000 + (32'($urandom_range(0, 15)) << 2);
                endcase
                if ($urandom_range(0, 2) == 0) begin
                    faultEn   = 1;
                    faultAddr = {a[31:2], 2'b00} + (32'($urandom_range(0, 6)) << 2);
                end else begin
                    faultEn = 0;
                end
                applyStimulus(0, rdy, 1, a);
            end else begin
                applyStimulus(0, rdy, 0, 0);
            end
        end
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
